sdr_wr_burst: RTL and testbench

SDR_WR_BURST -- requirements
Module: sdr_wr_burst

---
 rtl/sdr_wr_burst.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_sdr_wr_burst.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_wr_burst.sv
// SDRAM write-burst sequencer: drains a show-ahead FIFO into an SDRAM row with
// ACTIVE / WRITE / PRECHARGE sequencing, row crossing and refresh pausing.
module sdr_wr_burst #(
  parameter int unsigned DQ_W  = 16,
  parameter int unsigned BL    = 4,
  parameter int unsigned NRCD  = 3,
  parameter int unsigned NWR   = 2,
  parameter int unsigned NRP   = 3,
  parameter int unsigned LEN_W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_req,
  input  logic [LEN_W-1:0]    wr_len,
  input  logic [1:0]          wr_bank,
  input  logic [12:0]         wr_row,
  input  logic [8:0]          wr_col,
  output logic                wr_busy,
  output logic                wr_done,
  input  logic [3:0]          fifo_level,
  output logic                fifo_rd,
  input  logic [DQ_W-1:0]     fifo_data,
  input  logic                need_ref,
  output logic                wr_paused,
  output logic                sdr_cke,
  output logic                sdr_ncs,
  output logic                sdr_nras,
  output logic                sdr_ncas,
  output logic                sdr_nwe,
  output logic [1:0]          sdr_ba,
  output logic [12:0]         sdr_a,
  output logic [DQ_W-1:0]     sdr_dq_out,
  output logic                sdr_dq_oe,
  output logic [DQ_W/8-1:0]   sdr_dqm
);

  localparam int unsigned DM_W = DQ_W / 8;
  localparam int unsigned AW   = 24;
  localparam int unsigned TW   = 8;
  localparam int unsigned BW   = 4;

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE, S_ACTIVE, S_WRITE, S_WREC, S_PRECHARGE, S_PAUSE
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  wcnt_q, wcnt_d;
  logic [AW-1:0]     start_q, start_d;
  logic [1:0]        open_ba_q, open_ba_d;
  logic              did_burst_q, did_burst_d;
  logic [BW-1:0]     pop_rem_q, pop_rem_d;
  logic [BW-1:0]     beats_q, beats_d;
  logic              fifo_rd_q, fifo_rd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              paused_q, paused_d;
  logic [2:0]        cmd_q, cmd_d;
  logic [1:0]        ba_q, ba_d;
  logic [12:0]       a_q, a_d;
  logic [DQ_W-1:0]   dq_q, dq_d;
  logic              oe_q, oe_d;
  logic [DM_W-1:0]   dqm_q, dqm_d;
  logic              cke_q, cke_d;
  logic              ncs_q, ncs_d;

  logic [AW-1:0]     cur_addr;
  logic [8:0]        cur_col;
  logic [12:0]       cur_row;
  logic [1:0]        cur_ba;
  logic [LEN_W-1:0]  remaining;
  logic [BW-1:0]     room;
  logic [BW-1:0]     nb;
  logic              burst_busy;
  logic              open_cur;

  // Current address is the latched start plus words already popped, wrapping at 2^24.
  always_comb begin
    cur_addr   = start_q + AW'(wcnt_q);
    cur_col    = cur_addr[8:0];
    cur_row    = cur_addr[21:9];
    cur_ba     = cur_addr[23:22];
    remaining  = len_q - wcnt_q;
    room       = BW'(BL) - BW'(cur_col & 9'(BL - 1));
    nb         = (remaining < LEN_W'(room)) ? BW'(remaining) : room;
    burst_busy = fifo_rd_q | (pop_rem_q != '0) | (beats_q != '0);
  end

  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    len_d       = len_q;
    wcnt_d      = fifo_rd_q ? wcnt_q + LEN_W'(1) : wcnt_q;
    start_d     = start_q;
    open_ba_d   = open_ba_q;
    did_burst_d = did_burst_q;
    pop_rem_d   = pop_rem_q;
    beats_d     = beats_q;
    fifo_rd_d   = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    paused_d    = paused_q;
    cmd_d       = CMD_NOP;
    ba_d        = ba_q;
    a_d         = a_q;
    dq_d        = '0;
    oe_d        = 1'b0;
    dqm_d       = '1;
    cke_d       = 1'b1;
    ncs_d       = 1'b0;
    open_cur    = 1'b0;

    // Pop train and data beats; the WRITE command rides on the first beat.
    if (pop_rem_q != '0) begin
      fifo_rd_d = 1'b1;
      pop_rem_d = pop_rem_q - BW'(1);
    end
    if (beats_q != '0) begin
      oe_d    = 1'b1;
      beats_d = beats_q - BW'(1);
      dq_d    = fifo_rd_q ? fifo_data : '0;
      dqm_d   = fifo_rd_q ? '0 : '1;
      if (beats_q == BW'(BL)) begin
        cmd_d = CMD_WR;
        ba_d  = cur_ba;
        a_d   = {4'b0000, cur_col};
      end
    end

    case (state_q)
      S_IDLE: begin
        if (wr_req) begin
          if (wr_len != '0) begin
            len_d     = wr_len;
            start_d   = {wr_bank, wr_row, wr_col};
            wcnt_d    = '0;
            busy_d    = 1'b1;
            open_ba_d = wr_bank;
            cmd_d     = CMD_ACT;
            ba_d      = wr_bank;
            a_d       = wr_row;
            tcnt_d    = TW'(NRCD - 1);
            state_d   = S_ACTIVE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        if (tcnt_q == '0) begin
          did_burst_d = 1'b0;
          state_d     = S_WRITE;
        end else begin
          tcnt_d = tcnt_q - TW'(1);
        end
      end
      S_WRITE: begin
        if (!burst_busy) begin
          if (did_burst_q && (remaining == '0 || cur_col == '0 || need_ref)) begin
            tcnt_d  = TW'(NWR - 1);
            state_d = S_WREC;
          end else if (remaining != '0 && fifo_level >= nb) begin
            fifo_rd_d   = 1'b1;
            pop_rem_d   = nb - BW'(1);
            beats_d     = BW'(BL);
            did_burst_d = 1'b1;
          end
        end
      end
      S_WREC: begin
        if (tcnt_q == '0) begin
          cmd_d   = CMD_PRE;
          ba_d    = open_ba_q;
          a_d     = '0;
          tcnt_d  = TW'(NRP - 1);
          state_d = S_PRECHARGE;
        end else begin
          tcnt_d = tcnt_q - TW'(1);
        end
      end
      S_PRECHARGE: begin
        if (tcnt_q != '0) begin
          tcnt_d = tcnt_q - TW'(1);
        end else if (need_ref) begin
          paused_d = 1'b1;
          state_d  = S_PAUSE;
        end else if (remaining == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          open_cur = 1'b1;
        end
      end
      S_PAUSE: begin
        if (!need_ref) begin
          paused_d = 1'b0;
          if (remaining == '0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            open_cur = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Reopen at the current address, which may sit in a new row or bank.
    if (open_cur) begin
      cmd_d     = CMD_ACT;
      ba_d      = cur_ba;
      a_d       = cur_row;
      open_ba_d = cur_ba;
      tcnt_d    = TW'(NRCD - 1);
      state_d   = S_ACTIVE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tcnt_q      <= '0;
      len_q       <= '0;
      wcnt_q      <= '0;
      start_q     <= '0;
      open_ba_q   <= '0;
      did_burst_q <= 1'b0;
      pop_rem_q   <= '0;
      beats_q     <= '0;
      fifo_rd_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      paused_q    <= 1'b0;
      cmd_q       <= CMD_NOP;
      ba_q        <= '0;
      a_q         <= '0;
      dq_q        <= '0;
      oe_q        <= 1'b0;
      dqm_q       <= '1;
      cke_q       <= 1'b1;
      ncs_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      len_q       <= len_d;
      wcnt_q      <= wcnt_d;
      start_q     <= start_d;
      open_ba_q   <= open_ba_d;
      did_burst_q <= did_burst_d;
      pop_rem_q   <= pop_rem_d;
      beats_q     <= beats_d;
      fifo_rd_q   <= fifo_rd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      paused_q    <= paused_d;
      cmd_q       <= cmd_d;
      ba_q        <= ba_d;
      a_q         <= a_d;
      dq_q        <= dq_d;
      oe_q        <= oe_d;
      dqm_q       <= dqm_d;
      cke_q       <= cke_d;
      ncs_q       <= ncs_d;
    end
  end

  assign wr_busy    = busy_q;
  assign wr_done    = done_q;
  assign wr_paused  = paused_q;
  assign fifo_rd    = fifo_rd_q;
  assign sdr_cke    = cke_q;
  assign sdr_ncs    = ncs_q;
  assign sdr_nras   = cmd_q[2];
  assign sdr_ncas   = cmd_q[1];
  assign sdr_nwe    = cmd_q[0];
  assign sdr_ba     = ba_q;
  assign sdr_a      = a_q;
  assign sdr_dq_out = dq_q;
  assign sdr_dq_oe  = oe_q;
  assign sdr_dqm    = dqm_q;

endmodule

// File: tb/tb_sdr_wr_burst.sv
// Directed bench for sdr_wr_burst: logs SDRAM commands and data beats, then
// compares each scenario against hand-derived command/beat sequences.
module tb_sdr_wr_burst;

  localparam int unsigned LEN_W = 12;
  localparam int unsigned NWR   = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_req = 1'b0;
  logic [LEN_W-1:0] wr_len = '0;
  logic [1:0]       wr_bank = '0;
  logic [12:0]      wr_row = '0;
  logic [8:0]       wr_col = '0;
  logic             wr_busy, wr_done, fifo_rd, wr_paused;
  logic [3:0]       fifo_level = '0;
  logic [15:0]      fifo_data;
  logic             need_ref = 1'b0;
  logic             sdr_cke, sdr_ncs, sdr_nras, sdr_ncas, sdr_nwe, sdr_dq_oe;
  logic [1:0]       sdr_ba, sdr_dqm;
  logic [12:0]      sdr_a;
  logic [15:0]      sdr_dq_out;

  int checks = 0;
  int errors = 0;

  sdr_wr_burst dut (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_len(wr_len),
    .wr_bank(wr_bank), .wr_row(wr_row), .wr_col(wr_col),
    .wr_busy(wr_busy), .wr_done(wr_done), .fifo_level(fifo_level),
    .fifo_rd(fifo_rd), .fifo_data(fifo_data), .need_ref(need_ref),
    .wr_paused(wr_paused), .sdr_cke(sdr_cke), .sdr_ncs(sdr_ncs),
    .sdr_nras(sdr_nras), .sdr_ncas(sdr_ncas), .sdr_nwe(sdr_nwe),
    .sdr_ba(sdr_ba), .sdr_a(sdr_a), .sdr_dq_out(sdr_dq_out),
    .sdr_dq_oe(sdr_dq_oe), .sdr_dqm(sdr_dqm)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model: head word is a running counter.
  logic [15:0] word = '0;
  always @(posedge clk) if (fifo_rd) word <= word + 16'd1;
  assign fifo_data = 16'h1000 + word;

  logic [2:0]  cmd_w;
  assign cmd_w = {sdr_nras, sdr_ncas, sdr_nwe};

  logic [17:0] log_q[$];
  int          gap_q[$];
  logic [1:0]  dqm_q[$];
  logic [15:0] dq_q[$];
  int cyc = 0, pops = 0, dones = 0, last_oe = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (cmd_w != 3'b111) begin
        log_q.push_back({cmd_w, sdr_ba, sdr_a});
        gap_q.push_back(cyc - last_oe);
      end
      if (sdr_dq_oe) begin
        dqm_q.push_back(sdr_dqm);
        dq_q.push_back(sdr_dq_out);
        last_oe <= cyc;
      end
      if (fifo_rd) pops <= pops + 1;
      if (wr_done) dones <= dones + 1;
    end
  end

  function automatic logic [17:0] mk(input logic [2:0] c, input logic [1:0] b, input int a);
    return {c, b, 13'(a)};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [1:0] b, input int r, input int c, input int l);
    wr_bank = b; wr_row = 13'(r); wr_col = 9'(c); wr_len = LEN_W'(l);
    wr_req = 1'b1;
    cycles(1);
    wr_req = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      cycles(1);
      if (dones > d0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    cycles(2);
    checks++; if (cmd_w !== 3'b111) begin errors++; $display("FAIL rst_cmd got %b want 111", cmd_w); end
    checks++; if ({sdr_ba, sdr_a} !== 15'd0) begin errors++; $display("FAIL rst_addr got %h want 0", {sdr_ba, sdr_a}); end
    checks++; if ({sdr_dq_out, sdr_dq_oe, sdr_dqm} !== {16'h0, 1'b0, 2'b11}) begin
      errors++; $display("FAIL rst_dq got dq=%h oe=%b dqm=%b want 0/0/11", sdr_dq_out, sdr_dq_oe, sdr_dqm); end
    checks++; if ({fifo_rd, wr_busy, wr_done, wr_paused} !== 4'b0000) begin
      errors++; $display("FAIL rst_ctl got %b want 0000", {fifo_rd, wr_busy, wr_done, wr_paused}); end
    rst_n = 1'b1;
    cycles(2);
    checks++; if ({sdr_cke, sdr_ncs, cmd_w} !== 5'b10111) begin
      errors++; $display("FAIL idle_pins got %b want 10111", {sdr_cke, sdr_ncs, cmd_w}); end
  endtask

  task automatic test_basic();
    logic [17:0] exp [4];
    int c0 = log_q.size(), b0 = dqm_q.size(), p0 = pops, d0 = dones;
    logic [15:0] w0 = word;
    bit ok;
    exp = '{mk(3'b011, 0, 5), mk(3'b100, 0, 0), mk(3'b100, 0, 4), mk(3'b010, 0, 0)};
    fifo_level = 4'd8;
    start_xfer(2'd0, 5, 0, 8);
    checks++; if (wr_busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", wr_busy); end
    cycles(1);
    start_xfer(2'd3, 100, 7, 2);
    wait_done(d0, 300, ok);
    cycles(3);
    checks++; if (!ok || dones - d0 != 1) begin errors++; $display("FAIL basic_done got %0d want 1", dones - d0); end
    checks++; if (pops - p0 != 8) begin errors++; $display("FAIL basic_pops got %0d want 8", pops - p0); end
    checks++; if (log_q.size() - c0 != 4) begin errors++; $display("FAIL basic_ncmd got %0d want 4", log_q.size() - c0); end
    for (int i = 0; i < 4; i++) if (c0 + i < log_q.size()) begin
      checks++; if (log_q[c0+i] !== exp[i]) begin errors++; $display("FAIL basic_cmd%0d got %h want %h", i, log_q[c0+i], exp[i]); end
    end
    for (int i = 0; i < 8; i++) if (b0 + i < dq_q.size()) begin
      checks++; if ({dqm_q[b0+i], dq_q[b0+i]} !== {2'b00, 16'h1000 + w0 + 16'(i)}) begin
        errors++; $display("FAIL basic_beat%0d got %b/%h want 00/%h", i, dqm_q[b0+i], dq_q[b0+i], 16'h1000 + w0 + 16'(i)); end
    end
    checks++; if (wr_busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b want 0", wr_busy); end
  endtask

  task automatic test_partial();
    logic [17:0] exp [4];
    logic [1:0]  edqm [8];
    int c0 = log_q.size(), b0 = dqm_q.size(), p0 = pops, d0 = dones;
    bit ok;
    exp  = '{mk(3'b011, 1, 1), mk(3'b100, 1, 6), mk(3'b100, 1, 8), mk(3'b010, 1, 0)};
    edqm = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11};
    fifo_level = 4'd8;
    start_xfer(2'd1, 1, 6, 3);
    wait_done(d0, 300, ok);
    cycles(2);
    checks++; if (!ok || pops - p0 != 3) begin errors++; $display("FAIL part_pops got %0d want 3", pops - p0); end
    checks++; if (log_q.size() - c0 != 4) begin errors++; $display("FAIL part_ncmd got %0d want 4", log_q.size() - c0); end
    for (int i = 0; i < 4; i++) if (c0 + i < log_q.size()) begin
      checks++; if (log_q[c0+i] !== exp[i]) begin errors++; $display("FAIL part_cmd%0d got %h want %h", i, log_q[c0+i], exp[i]); end
    end
    checks++; if (dqm_q.size() - b0 != 8) begin errors++; $display("FAIL part_nbeat got %0d want 8", dqm_q.size() - b0); end
    for (int i = 0; i < 8; i++) if (b0 + i < dqm_q.size()) begin
      checks++; if (dqm_q[b0+i] !== edqm[i]) begin errors++; $display("FAIL part_dqm%0d got %b want %b", i, dqm_q[b0+i], edqm[i]); end
    end
  endtask

  task automatic test_row_cross();
    logic [17:0] exp [12];
    logic [1:0]  edqm [16];
    int c0 = log_q.size(), b0 = dqm_q.size(), d0 = dones;
    bit ok;
    exp  = '{mk(3'b011, 0, 2), mk(3'b100, 0, 508), mk(3'b010, 0, 0),
             mk(3'b011, 0, 3), mk(3'b100, 0, 0), mk(3'b010, 0, 0),
             mk(3'b011, 0, 8191), mk(3'b100, 0, 511), mk(3'b010, 0, 0),
             mk(3'b011, 1, 0), mk(3'b100, 1, 0), mk(3'b010, 1, 0)};
    edqm = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11,
             2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11};
    fifo_level = 4'd8;
    start_xfer(2'd0, 2, 508, 6);
    wait_done(d0, 400, ok);
    cycles(2);
    start_xfer(2'd0, 8191, 511, 2);
    wait_done(d0 + 1, 400, ok);
    cycles(2);
    checks++; if (!ok || dones - d0 != 2) begin errors++; $display("FAIL cross_done got %0d want 2", dones - d0); end
    checks++; if (log_q.size() - c0 != 12) begin errors++; $display("FAIL cross_ncmd got %0d want 12", log_q.size() - c0); end
    for (int i = 0; i < 12; i++) if (c0 + i < log_q.size()) begin
      checks++; if (log_q[c0+i] !== exp[i]) begin errors++; $display("FAIL cross_cmd%0d got %h want %h", i, log_q[c0+i], exp[i]); end
    end
    for (int i = 0; i < 16; i++) if (b0 + i < dqm_q.size()) begin
      checks++; if (dqm_q[b0+i] !== edqm[i]) begin errors++; $display("FAIL cross_dqm%0d got %b want %b", i, dqm_q[b0+i], edqm[i]); end
    end
  endtask

  task automatic test_refresh();
    logic [17:0] exp [8];
    int c0 = log_q.size(), p0 = pops, d0 = dones;
    bit ok;
    exp = '{mk(3'b011, 0, 7), mk(3'b100, 0, 0), mk(3'b100, 0, 4), mk(3'b010, 0, 0),
            mk(3'b011, 0, 7), mk(3'b100, 0, 8), mk(3'b100, 0, 12), mk(3'b010, 0, 0)};
    fifo_level = 4'd8;
    start_xfer(2'd0, 7, 0, 16);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin cycles(1); if (pops - p0 >= 5) begin ok = 1'b1; break; end end
    need_ref = 1'b1;
    checks++; if (!ok) begin errors++; $display("FAIL ref_reach5 got %0d want 5", pops - p0); end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin cycles(1); if (wr_paused) begin ok = 1'b1; break; end end
    checks++; if (!ok) begin errors++; $display("FAIL ref_paused got %b want 1", wr_paused); end
    checks++; if (pops - p0 != 8) begin errors++; $display("FAIL ref_pops_mid got %0d want 8", pops - p0); end
    checks++; if (log_q.size() - c0 != 4) begin errors++; $display("FAIL ref_ncmd_mid got %0d want 4", log_q.size() - c0); end
    if (c0 + 3 < gap_q.size()) begin
      checks++; if (gap_q[c0+3] < NWR + 1) begin errors++; $display("FAIL ref_twr got %0d want >=%0d", gap_q[c0+3], NWR + 1); end
    end
    cycles(5);
    checks++; if ({wr_paused, cmd_w} !== 4'b1111 || log_q.size() - c0 != 4 || dones != d0) begin
      errors++; $display("FAIL ref_hold got paused=%b cmd=%b n=%0d want 1/111/4", wr_paused, cmd_w, log_q.size() - c0); end
    need_ref = 1'b0;
    wait_done(d0, 300, ok);
    cycles(2);
    checks++; if (!ok || pops - p0 != 16) begin errors++; $display("FAIL ref_pops got %0d want 16", pops - p0); end
    checks++; if (log_q.size() - c0 != 8) begin errors++; $display("FAIL ref_ncmd got %0d want 8", log_q.size() - c0); end
    for (int i = 0; i < 8; i++) if (c0 + i < log_q.size()) begin
      checks++; if (log_q[c0+i] !== exp[i]) begin errors++; $display("FAIL ref_cmd%0d got %h want %h", i, log_q[c0+i], exp[i]); end
    end
  endtask

  task automatic test_refresh_last();
    logic [17:0] exp [3];
    int c0 = log_q.size(), d0 = dones;
    bit ok;
    exp = '{mk(3'b011, 2, 11), mk(3'b100, 2, 0), mk(3'b010, 2, 0)};
    fifo_level = 4'd8;
    start_xfer(2'd2, 11, 0, 4);
    need_ref = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin cycles(1); if (wr_paused) begin ok = 1'b1; break; end end
    checks++; if (!ok || dones != d0) begin errors++; $display("FAIL last_pause got paused=%b done=%0d want 1/0", wr_paused, dones - d0); end
    cycles(3);
    need_ref = 1'b0;
    wait_done(d0, 50, ok);
    cycles(5);
    checks++; if (!ok || wr_busy !== 1'b0) begin errors++; $display("FAIL last_done got ok=%b busy=%b want 1/0", ok, wr_busy); end
    checks++; if (log_q.size() - c0 != 3) begin errors++; $display("FAIL last_ncmd got %0d want 3", log_q.size() - c0); end
    for (int i = 0; i < 3; i++) if (c0 + i < log_q.size()) begin
      checks++; if (log_q[c0+i] !== exp[i]) begin errors++; $display("FAIL last_cmd%0d got %h want %h", i, log_q[c0+i], exp[i]); end
    end
  endtask

  task automatic test_fifo_starve();
    logic [17:0] exp [3];
    int c0 = log_q.size(), p0 = pops, d0 = dones;
    bit ok;
    exp = '{mk(3'b011, 0, 9), mk(3'b100, 0, 0), mk(3'b010, 0, 0)};
    fifo_level = 4'd2;
    start_xfer(2'd0, 9, 0, 4);
    cycles(20);
    checks++; if (pops - p0 != 0 || log_q.size() - c0 != 1) begin
      errors++; $display("FAIL starve_hold got pops=%0d ncmd=%0d want 0/1", pops - p0, log_q.size() - c0); end
    fifo_level = 4'd4;
    wait_done(d0, 200, ok);
    cycles(2);
    checks++; if (!ok || pops - p0 != 4) begin errors++; $display("FAIL starve_pops got %0d want 4", pops - p0); end
    checks++; if (log_q.size() - c0 != 3) begin errors++; $display("FAIL starve_ncmd got %0d want 3", log_q.size() - c0); end
    for (int i = 0; i < 3; i++) if (c0 + i < log_q.size()) begin
      checks++; if (log_q[c0+i] !== exp[i]) begin errors++; $display("FAIL starve_cmd%0d got %h want %h", i, log_q[c0+i], exp[i]); end
    end
  endtask

  task automatic test_zero_len();
    int c0 = log_q.size(), d0 = dones;
    start_xfer(2'd1, 3, 0, 0);
    checks++; if ({wr_done, wr_busy} !== 2'b10) begin errors++; $display("FAIL zero_pulse got %b want 10", {wr_done, wr_busy}); end
    cycles(1);
    checks++; if (wr_done !== 1'b0) begin errors++; $display("FAIL zero_clear got %b want 0", wr_done); end
    cycles(5);
    checks++; if (log_q.size() != c0 || dones - d0 != 1) begin
      errors++; $display("FAIL zero_cmd got ncmd=%0d done=%0d want 0/1", log_q.size() - c0, dones - d0); end
  endtask

  task automatic test_reset_mid();
    int c0 = log_q.size(), d0 = dones;
    fifo_level = 4'd8;
    start_xfer(2'd0, 20, 0, 8);
    cycles(1);
    rst_n = 1'b0;
    #1;
    checks++; if ({cmd_w, sdr_ba, sdr_a, sdr_dq_oe, sdr_dqm} !== {3'b111, 15'd0, 1'b0, 2'b11}) begin
      errors++; $display("FAIL mid_rst_pins got cmd=%b a=%h oe=%b dqm=%b", cmd_w, sdr_a, sdr_dq_oe, sdr_dqm); end
    checks++; if ({fifo_rd, wr_busy, wr_done, wr_paused, sdr_dq_out} !== 20'd0) begin
      errors++; $display("FAIL mid_rst_ctl got %b want 0", {fifo_rd, wr_busy, wr_done, wr_paused}); end
    cycles(2);
    rst_n = 1'b1;
    cycles(40);
    checks++; if (dones != d0 || log_q.size() - c0 != 1) begin
      errors++; $display("FAIL mid_rst_after got done=%0d ncmd=%0d want 0/1", dones - d0, log_q.size() - c0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_row_cross();
    test_refresh();
    test_refresh_last();
    test_fifo_starve();
    test_zero_len();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
